// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - CPU store buffer: circular FIFO of pending stores, in-order drain, load forwarding
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          pop;

  // Fullness is judged on the registered count, so a pop at the same edge cannot unstall.
  assign cpu_stall = cpu_we & (count == FULL);
  assign accept    = cpu_we & (count != FULL);
  assign pop       = (state == REQ) & mem_ack & (count != '0);
  assign empty     = (count == '0);

  assign mem_addr  = addr_mem[rd_ptr];
  assign mem_wdata = data_mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (accept && !pop) begin
      count_next = count + 1'b1;
    end else if (!accept && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack && (count_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry payload is not reset; validity comes only from rd_ptr/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[wr_ptr] <= cpu_addr;
      data_mem[wr_ptr] <= cpu_wdata;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    cpu_rdata = mem_rdata;
    idx       = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (addr_mem[idx] == cpu_addr)) begin
        cpu_rdata = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer with a drain-order scoreboard
module tb_store_buffer;

  logic       clk;
  logic       reset;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [2:0] count;
  logic       empty;

  int checks = 0;
  int errors = 0;
  int drains = 0;
  int d0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;

  store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one store that the bench's own model expects to be accepted at the next edge.
  task automatic store(input logic [7:0] a, input logic [7:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    exp_q.push_back({a, d});
    step();
    cpu_we = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 50) begin
      step();
      n++;
    end
    check("wait_empty", 32'(empty), 32'd1);
  endtask

  // A write retires at the edge following a negedge that sees mem_req & mem_ack.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("drain_extra", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("drain_addr", 32'(mem_addr), 32'(mon_e[15:8]));
        check("drain_data", 32'(mem_wdata), 32'(mon_e[7:0]));
      end
      drains++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single store with ack tied high
    mem_ack = 1'b1;
    d0 = drains;
    store(8'h3C, 8'h1C);
    check("single_count", 32'(count), 32'd1);
    check("single_latency", 32'(mem_req), 32'd0);
    step();
    check("single_req", 32'(mem_req), 32'd1);
    check("single_addr", 32'(mem_addr), 32'h3C);
    check("single_data", 32'(mem_wdata), 32'h1C);
    step();
    check("single_req_off", 32'(mem_req), 32'd0);
    check("single_empty", 32'(empty), 32'd1);
    check("single_drains", 32'(drains - d0), 32'd1);

    // Fill to full, stall the fifth, free one slot
    mem_ack = 1'b0;
    d0 = drains;
    for (int i = 0; i < 4; i++) store(8'h10 + 8'(i), 8'h10 + 8'(i));
    cpu_we    = 1'b1;
    cpu_addr  = 8'h14;
    cpu_wdata = 8'h14;
    #2;
    check("fill_count", 32'(count), 32'd4);
    check("fill_stall", 32'(cpu_stall), 32'd1);
    check("fill_head", 32'(mem_addr), 32'h10);
    mem_ack = 1'b1;
    step();
    check("fill_pop_count", 32'(count), 32'd3);
    check("fill_unstall", 32'(cpu_stall), 32'd0);
    mem_ack = 1'b0;
    exp_q.push_back({8'h14, 8'h14});
    step();
    cpu_we = 1'b0;
    check("fill_refill", 32'(count), 32'd4);
    mem_ack = 1'b1;
    wait_empty();
    check("fill_drains", 32'(drains - d0), 32'd5);

    // Forwarding: youngest match wins, misses fall through to memory
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    d0 = drains;
    store(8'h20, 8'hAA);
    store(8'h20, 8'hBB);
    cpu_addr = 8'h20;
    #1;
    check("fwd_youngest", 32'(cpu_rdata), 32'hBB);
    cpu_addr = 8'h21;
    #1;
    check("fwd_miss", 32'(cpu_rdata), 32'h00);
    mem_rdata = 8'h44;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h22;
    cpu_wdata = 8'h99;
    exp_q.push_back({8'h22, 8'h99});
    #1;
    check("fwd_same_edge", 32'(cpu_rdata), 32'h44);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    check("fwd_after_edge", 32'(cpu_rdata), 32'h99);
    mem_ack = 1'b1;
    wait_empty();
    check("fwd_drains", 32'(drains - d0), 32'd3);

    // Backpressure: head held stable while ack is low
    mem_ack = 1'b0;
    d0 = drains;
    store(8'h40, 8'h41);
    store(8'h42, 8'h43);
    for (int i = 0; i < 3; i++) begin
      check("bp_req", 32'(mem_req), 32'd1);
      check("bp_addr", 32'(mem_addr), 32'h40);
      check("bp_data", 32'(mem_wdata), 32'h41);
      check("bp_count", 32'(count), 32'd2);
      step();
    end
    mem_ack = 1'b1;
    step();
    check("bp_pop_count", 32'(count), 32'd1);
    check("bp_next_addr", 32'(mem_addr), 32'h42);
    wait_empty();
    check("bp_drains", 32'(drains - d0), 32'd2);

    // Pointer wrap with continuous drain
    mem_ack = 1'b1;
    d0 = drains;
    for (int i = 0; i < 10; i++) store(8'h50 + 8'(i), 8'hA0 + 8'(i));
    wait_empty();
    check("wrap_drains", 32'(drains - d0), 32'd10);
    check("wrap_count", 32'(count), 32'd0);

    // Asynchronous reset mid-drain discards everything
    mem_ack = 1'b0;
    store(8'h60, 8'h01);
    store(8'h61, 8'h02);
    store(8'h62, 8'h03);
    check("rst_mid_count", 32'(count), 32'd3);
    check("rst_mid_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_req", 32'(mem_req), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    check("rst_async_empty", 32'(empty), 32'd1);
    exp_q.delete();
    step();
    step();
    reset   = 1'b0;
    mem_ack = 1'b1;
    d0 = drains;
    repeat (5) step();
    check("rst_no_writes", 32'(drains - d0), 32'd0);
    check("rst_idle_req", 32'(mem_req), 32'd0);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
